// File: rtl/alu_result_checker.sv
// alu_result_checker: recomputes the golden ADD/SUB/AND/OR result and flags for
// each ALU sample and compares them with what the ALU returned. Results are
// registered one cycle after the sample: a mismatch pulse, pass/fail status,
// saturating counters and a capture of the first failing sample.
//
// Handshake: in_valid has no ready partner. The checker accepts a sample on
// every rising edge where in_valid=1, reset=0 and clear=0. Samples may arrive
// on consecutive cycles and are never stalled.
module alu_result_checker #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [N-1:0] src_a,
  input  logic [N-1:0] src_b,
  input  logic [1:0]   ALU_Control,
  input  logic [N-1:0] ALU_out,
  input  logic         zero_flag,
  input  logic         carry_flag,
  input  logic         sign_flag,
  input  logic         overflow_flag,
  input  logic         clear,
  output logic         mismatch,
  output logic [1:0]   status,
  output logic [15:0]  check_count,
  output logic [15:0]  error_count,
  output logic [1:0]   first_err_op,
  output logic [N-1:0] first_err_a,
  output logic [N-1:0] first_err_b,
  output logic [4:0]   first_err_mask
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PASS = 2'b01,
    ST_FAIL = 2'b10
  } state_t;

  state_t       state_q;
  state_t       state_d;

  logic [N-1:0] b_eff;
  logic         carry_in;
  logic [N:0]   sum;
  logic [N-1:0] g_res;
  logic         g_z;
  logic         g_c;
  logic         g_s;
  logic         g_v;
  logic [4:0]   cmp_mask;
  logic         fail;
  logic         accept;

  // Golden model: SUB reuses the adder as a + ~b + 1 so its carry means a >= b.
  always_comb begin
    b_eff    = (ALU_Control == OP_SUB) ? ~src_b : src_b;
    carry_in = (ALU_Control == OP_SUB);
    sum      = {1'b0, src_a} + {1'b0, b_eff} + {{N{1'b0}}, carry_in};
    g_res    = '0;
    g_c      = 1'b0;
    g_v      = 1'b0;
    case (ALU_Control)
      OP_ADD: begin
        g_res = sum[N-1:0];
        g_c   = sum[N];
        g_v   = (src_a[N-1] == src_b[N-1]) && (sum[N-1] != src_a[N-1]);
      end
      OP_SUB: begin
        g_res = sum[N-1:0];
        g_c   = sum[N];
        g_v   = (src_a[N-1] != src_b[N-1]) && (sum[N-1] != src_a[N-1]);
      end
      OP_AND:  g_res = src_a & src_b;
      default: g_res = src_a | src_b;
    endcase
    g_z      = (g_res == '0);
    g_s      = g_res[N-1];
    cmp_mask = {ALU_out != g_res, zero_flag != g_z, carry_flag != g_c,
                sign_flag != g_s, overflow_flag != g_v};
    fail     = |cmp_mask;
    accept   = in_valid && !clear;
  end

  // State register: reset and clear both return to IDLE, reset taking priority.
  always_ff @(posedge clk) begin
    if (reset || clear) state_q <= ST_IDLE;
    else                state_q <= state_d;
  end

  // Next state: any failure lands in FAIL, which then absorbs further samples.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      case (state_q)
        ST_IDLE: state_d = fail ? ST_FAIL : ST_PASS;
        ST_PASS: state_d = fail ? ST_FAIL : ST_PASS;
        default: state_d = ST_FAIL;
      endcase
    end
  end

  // Output decode: the status code is the state encoding itself.
  always_comb begin
    status = state_q;
  end

  // Result registers: pulse, saturating counters, capture on entry to FAIL.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      mismatch       <= 1'b0;
      check_count    <= '0;
      error_count    <= '0;
      first_err_op   <= '0;
      first_err_a    <= '0;
      first_err_b    <= '0;
      first_err_mask <= '0;
    end else if (accept) begin
      mismatch <= fail;
      if (check_count != 16'hFFFF) check_count <= check_count + 16'd1;
      if (fail && (error_count != 16'hFFFF)) error_count <= error_count + 16'd1;
      if (fail && (state_q != ST_FAIL)) begin
        first_err_op   <= ALU_Control;
        first_err_a    <= src_a;
        first_err_b    <= src_b;
        first_err_mask <= cmp_mask;
      end
    end else begin
      mismatch <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_result_checker.sv
// tb_alu_result_checker: directed vectors at N=2 with hand-computed expected
// outputs for alu_result_checker.
module tb_alu_result_checker;

  localparam int N = 2;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic [N-1:0] src_a;
  logic [N-1:0] src_b;
  logic [1:0]   ALU_Control;
  logic [N-1:0] ALU_out;
  logic         zero_flag;
  logic         carry_flag;
  logic         sign_flag;
  logic         overflow_flag;
  logic         clear;
  logic         mismatch;
  logic [1:0]   status;
  logic [15:0]  check_count;
  logic [15:0]  error_count;
  logic [1:0]   first_err_op;
  logic [N-1:0] first_err_a;
  logic [N-1:0] first_err_b;
  logic [4:0]   first_err_mask;

  int n_vec  = 0;
  int n_miss = 0;
  logic [0:0] exp_q[$];

  alu_result_checker #(.N(N)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .src_a(src_a), .src_b(src_b),
    .ALU_Control(ALU_Control), .ALU_out(ALU_out), .zero_flag(zero_flag),
    .carry_flag(carry_flag), .sign_flag(sign_flag), .overflow_flag(overflow_flag),
    .clear(clear), .mismatch(mismatch), .status(status), .check_count(check_count),
    .error_count(error_count), .first_err_op(first_err_op), .first_err_a(first_err_a),
    .first_err_b(first_err_b), .first_err_mask(first_err_mask)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Checking task
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver: present one cycle of inputs, then land 1 time unit after the edge.
  task automatic apply(input logic v, input logic cl, input logic [1:0] op,
                       input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] o,
                       input logic z, input logic c, input logic s, input logic fv);
    in_valid = v; clear = cl; ALU_Control = op; src_a = a; src_b = b; ALU_out = o;
    zero_flag = z; carry_flag = c; sign_flag = s; overflow_flag = fv;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    apply(1'b0, 1'b0, 2'b00, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_mismatch"}, 32'(mismatch), 32'd0);
    check({tag, "_status"}, 32'(status), 32'd0);
    check({tag, "_check_count"}, 32'(check_count), 32'd0);
    check({tag, "_error_count"}, 32'(error_count), 32'd0);
    check({tag, "_op"}, 32'(first_err_op), 32'd0);
    check({tag, "_a"}, 32'(first_err_a), 32'd0);
    check({tag, "_b"}, 32'(first_err_b), 32'd0);
    check({tag, "_mask"}, 32'(first_err_mask), 32'd0);
  endtask

  // Scoreboard for back-to-back samples: expected mismatch per sample.
  task automatic apply_scored(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                              input logic [N-1:0] o, input logic z, input logic c,
                              input logic s, input logic fv, input logic exp_mm);
    logic [0:0] e;
    exp_q.push_back(exp_mm);
    apply(1'b1, 1'b0, op, a, b, o, z, c, s, fv);
    e = exp_q.pop_front();
    check("b2b_mismatch", 32'(mismatch), 32'(e));
  endtask

  // Stimulus and final report
  initial begin
    reset = 1'b1;
    idle_cycle();
    idle_cycle();
    check_reset_state("reset");
    reset = 1'b0;

    // Correct ADD 3+1 wraps to 0 with carry
    apply(1, 0, 2'b00, 2'd3, 2'd1, 2'd0, 1, 1, 0, 0);
    check("add_ok_mismatch", 32'(mismatch), 32'd0);
    check("add_ok_status", 32'(status), 32'd1);
    check("add_ok_count", 32'(check_count), 32'd1);
    check("add_ok_errors", 32'(error_count), 32'd0);

    // in_valid low: nothing moves
    idle_cycle();
    check("idle_mismatch", 32'(mismatch), 32'd0);
    check("idle_count", 32'(check_count), 32'd1);
    check("idle_status", 32'(status), 32'd1);

    // ADD 1+1 with V missing
    apply(1, 0, 2'b00, 2'd1, 2'd1, 2'd2, 0, 0, 1, 0);
    check("add_bad_mismatch", 32'(mismatch), 32'd1);
    check("add_bad_status", 32'(status), 32'd2);
    check("add_bad_mask", 32'(first_err_mask), 32'h01);
    check("add_bad_op", 32'(first_err_op), 32'd0);
    check("add_bad_a", 32'(first_err_a), 32'd1);
    check("add_bad_b", 32'(first_err_b), 32'd1);
    check("add_bad_errors", 32'(error_count), 32'd1);
    check("add_bad_count", 32'(check_count), 32'd2);

    // Correct SUB 2-3 while in FAIL, then a wrong SUB
    apply(1, 0, 2'b01, 2'd2, 2'd3, 2'd3, 0, 0, 1, 0);
    check("sub_ok_mismatch", 32'(mismatch), 32'd0);
    check("sub_ok_status", 32'(status), 32'd2);
    check("sub_ok_count", 32'(check_count), 32'd3);
    apply(1, 0, 2'b01, 2'd2, 2'd3, 2'd0, 0, 0, 1, 0);
    check("sub_bad_mismatch", 32'(mismatch), 32'd1);
    check("sub_bad_status", 32'(status), 32'd2);
    check("sub_bad_errors", 32'(error_count), 32'd2);
    check("sub_bad_mask_held", 32'(first_err_mask), 32'h01);
    check("sub_bad_op_held", 32'(first_err_op), 32'd0);
    check("sub_bad_a_held", 32'(first_err_a), 32'd1);
    check("sub_bad_b_held", 32'(first_err_b), 32'd1);
    idle_cycle();
    check("pulse_end", 32'(mismatch), 32'd0);

    // Clear, then back-to-back correct AND/OR samples
    apply(0, 1, 2'b00, 2'd0, 2'd0, 2'd0, 0, 0, 0, 0);
    check_reset_state("clear");
    apply_scored(2'b10, 2'd3, 2'd1, 2'd1, 0, 0, 0, 0, 1'b0);
    apply_scored(2'b11, 2'd2, 2'd1, 2'd3, 0, 0, 1, 0, 1'b0);
    apply_scored(2'b10, 2'd2, 2'd1, 2'd0, 1, 0, 0, 0, 1'b0);
    apply_scored(2'b11, 2'd0, 2'd0, 2'd0, 1, 0, 0, 0, 1'b0);
    apply_scored(2'b10, 2'd3, 2'd2, 2'd2, 0, 0, 1, 0, 1'b0);
    check("b2b_count", 32'(check_count), 32'd5);
    check("b2b_errors", 32'(error_count), 32'd0);
    check("b2b_status", 32'(status), 32'd1);

    // Carry/overflow corner cases, all correct
    apply_scored(2'b01, 2'd3, 2'd1, 2'd2, 0, 1, 1, 0, 1'b0);
    apply_scored(2'b01, 2'd1, 2'd2, 2'd3, 0, 0, 1, 1, 1'b0);
    apply_scored(2'b00, 2'd1, 2'd1, 2'd2, 0, 0, 1, 1, 1'b0);
    apply_scored(2'b01, 2'd1, 2'd1, 2'd0, 1, 1, 0, 0, 1'b0);
    check("corner_count", 32'(check_count), 32'd9);
    check("corner_status", 32'(status), 32'd1);

    // Failing sample together with clear is discarded
    apply(1, 1, 2'b00, 2'd1, 2'd1, 2'd0, 0, 0, 0, 0);
    check_reset_state("clear_discard");

    // Failing sample just before reset leaves nothing behind
    apply(1, 0, 2'b00, 2'd1, 2'd1, 2'd0, 0, 0, 0, 0);
    check("pre_reset_mismatch", 32'(mismatch), 32'd1);
    reset = 1'b1;
    apply(1, 1, 2'b00, 2'd1, 2'd1, 2'd0, 0, 0, 0, 0);
    reset = 1'b0;
    idle_cycle();
    check_reset_state("pre_reset");

    // Saturate both counters with failures (ADD 0+0 reported as 1, Z low)
    for (int i = 0; i < 65535; i++) begin
      apply(1, 0, 2'b00, 2'd0, 2'd0, 2'd1, 0, 0, 0, 0);
    end
    check("sat_errors", 32'(error_count), 32'hFFFF);
    check("sat_count", 32'(check_count), 32'hFFFF);
    check("sat_mask", 32'(first_err_mask), 32'h18);
    apply(1, 0, 2'b00, 2'd0, 2'd0, 2'd1, 0, 0, 0, 0);
    check("sat_hold_errors", 32'(error_count), 32'hFFFF);
    check("sat_hold_count", 32'(check_count), 32'hFFFF);
    check("sat_hold_mismatch", 32'(mismatch), 32'd1);
    check("sat_hold_status", 32'(status), 32'd2);

    // Reset wins over clear and in_valid
    reset = 1'b1;
    apply(1, 1, 2'b00, 2'd0, 2'd0, 2'd1, 0, 0, 0, 0);
    reset = 1'b0;
    check_reset_state("final_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
